if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode.
- Decouples IF from ID stalls with a valid/ready handshake on both sides.
- Supports a whole-queue flush for branch/jump redirect.
- Presents a zero bubble (pc = 0, inst = 0) to ID whenever no valid entry is available, as the single-entry register did.

Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, number of entries; power of two, minimum 2
- PTR_W, 2, log2(DEPTH); must be kept consistent with DEPTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush_i  input  1  discard all entries, including this cycle's push (branch redirect)
- if_valid_i  input  1  IF presents an instruction this cycle
- if_pc_i  input  ADDR_W  PC of pushed instruction
- if_inst_i  input  INST_W  pushed instruction word
- if_ready_o  output  1  queue can accept a push; equals !full, registered-state only
- id_valid_o  output  1  head entry valid; equals !empty
- id_pc_o  output  ADDR_W  head PC, 0 when empty
- id_inst_o  output  INST_W  head instruction, 0 when empty
- id_ready_i  input  1  ID consumes the head this cycle
- count_o  output  PTR_W+1  number of occupied entries, 0..DEPTH

Behaviour:
- State:
  - storage array of DEPTH {pc, inst} entries
  - rd_ptr and wr_ptr, PTR_W bits each, wrapping modulo DEPTH
  - count register, PTR_W+1 bits
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0. Resulting outputs: if_ready_o=1, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0. Storage contents are don't-care.
- Handshake qualifiers:
  - push = if_valid_i & if_ready_o
  - pop = id_valid_o & id_ready_i
- Push: write {if_pc_i, if_inst_i} at wr_ptr; wr_ptr+1.
- Pop: rd_ptr+1.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance
- Latency: an entry pushed at edge N appears on id_* from edge N onward, i.e. it is consumable in cycle N+1. There is no same-cycle bypass from IF to ID, even when the queue is empty.
- Output path: id_* are a combinational mux of the head entry gated by !empty. id_* carry no combinational dependence on if_* or id_ready_i.
- Full (count=DEPTH):
  - if_ready_o=0 and pushes are ignored.
  - A pop in the same cycle does NOT enable a push; if_ready_o rises the following cycle. No ready path from id_ready_i to if_ready_o.
- Empty (count=0):
  - id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - id_ready_i is ignored; no underflow.
- Flush:
  - Priority: rst > flush_i > push/pop.
  - flush_i=1 at posedge: rd_ptr=wr_ptr=0, count=0. Any push or pop in that cycle is discarded.
  - Following cycle: id_valid_o=0, if_ready_o=1.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble; ordering is strictly FIFO.
- Invariant: count_o always equals (wr_ptr - rd_ptr) mod DEPTH, except at count=DEPTH where the two pointers are equal.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> if_ready_o=1, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0.
- Fill to full with id_ready_i=0:
  - Stimulus: push pc 0x00,0x04,0x08,0x0C (insts 0x00000013, 0x00100093, 0x00200113, 0x00300193).
  - Response: count_o 1..4, if_ready_o=0 after 4th push; a 5th push (pc 0x10) is ignored; id_pc_o stays 0x00.
- Drain with wrap:
  - Stimulus: from full, id_ready_i=1 and simultaneous pushes of pc 0x10, 0x14.
  - Response: pops 0x00..0x0C in order, then 0x10, 0x14. The push coincident with the first pop is rejected (if_ready_o=0 that cycle). count_o never exceeds 4. Pointers wrap.
- Simultaneous push/pop at mid-fill:
  - Stimulus: count=2, push pc 0x20 with pop.
  - Response: count_o stays 2; head advances to next entry; 0x20 emerges after the existing entries.
- Flush with concurrent push:
  - Stimulus: count=3, flush_i=1, if_valid_i=1 with pc 0x40.
  - Response: next cycle count_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0. pc 0x40 is never observed. The following push of pc 0x80 appears as head one cycle later.
- Reset mid-operation:
  - Stimulus: count=3, rst=1 together with push, pop and flush.
  - Response: next cycle all outputs equal their reset values; subsequent pushes start at slot 0 in order.

Source files
------------

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   DEPTH-entry instruction queue between fetch (IF) and decode (ID).
//   Valid/ready handshake on both sides lets IF run ahead of ID stalls.
//   A whole-queue flush supports branch/jump redirect.
//   ID sees a zero bubble (pc = 0, inst = 0) whenever the queue is empty.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush_i                   discard every entry, including this cycle's push
//   if_valid_i / if_ready_o   IF push handshake
//   if_pc_i, if_inst_i        pushed entry
//   id_valid_o / id_ready_i   ID pop handshake
//   id_pc_o, id_inst_o        head entry, zero when empty
//   count_o                   occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              if_ready_o,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Full/empty come from registered count only, so if_ready_o never sees a
  // same-cycle pop and id_* never see a same-cycle push.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign if_ready_o = !full;
  assign id_valid_o = !empty;
  assign count_o    = count;

  assign push = if_valid_i & if_ready_o;
  assign pop  = id_valid_o & id_ready_i;

  assign id_pc_o   = empty ? '0 : pc_mem[rd_ptr];
  assign id_inst_o = empty ? '0 : inst_mem[rd_ptr];

  // Control state: pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap naturally at DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage: no reset; contents only matter once count marks them valid.
  always_ff @(posedge clk) begin
    if (push && !flush_i && !rst) begin
      pc_mem[wr_ptr]   <= if_pc_i;
      inst_mem[wr_ptr] <= if_inst_i;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        if_ready_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic [2:0]  count_o;

  int nvec = 0;
  int nmis = 0;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .if_valid_i(if_valid_i),
    .if_pc_i   (if_pc_i),
    .if_inst_i (if_inst_i),
    .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o),
    .id_pc_o   (id_pc_o),
    .id_inst_o (id_inst_o),
    .id_ready_i(id_ready_i),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word used for a given pc: the four fill instructions, and a
  // recognisable tag for every other pc.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    case (pc)
      32'h00:  return 32'h0000_0013;
      32'h04:  return 32'h0010_0093;
      32'h08:  return 32'h0020_0113;
      32'h0C:  return 32'h0030_0193;
      default: return 32'hA000_0000 | pc;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst_of(pc);
    id_ready_i = rdy;
    flush_i    = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    nvec++; if (if_ready_o !== 1'b1) begin nmis++; $display("FAIL reset_ready: got %b expected 1", if_ready_o); end
    nvec++; if (id_valid_o !== 1'b0) begin nmis++; $display("FAIL reset_valid: got %b expected 0", id_valid_o); end
    nvec++; if (id_pc_o !== 32'h0) begin nmis++; $display("FAIL reset_pc: got %h expected 0", id_pc_o); end
    nvec++; if (id_inst_o !== 32'h0) begin nmis++; $display("FAIL reset_inst: got %h expected 0", id_inst_o); end
    nvec++; if (count_o !== 3'd0) begin nmis++; $display("FAIL reset_count: got %0d expected 0", count_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      nvec++; if (if_ready_o !== 1'b1) begin nmis++; $display("FAIL fill_ready_%0d: got %b expected 1", i, if_ready_o); end
      tick();
      nvec++; if (count_o !== 3'(i + 1)) begin nmis++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, count_o, i + 1); end
      nvec++; if (id_pc_o !== 32'h0) begin nmis++; $display("FAIL fill_head_%0d: got %h expected 0", i, id_pc_o); end
    end
    nvec++; if (if_ready_o !== 1'b0) begin nmis++; $display("FAIL full_ready: got %b expected 0", if_ready_o); end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    nvec++; if (count_o !== 3'd4) begin nmis++; $display("FAIL full_push_count: got %0d expected 4", count_o); end
    nvec++; if (id_pc_o !== 32'h0) begin nmis++; $display("FAIL full_head_pc: got %h expected 0", id_pc_o); end
    nvec++; if (id_inst_o !== 32'h0000_0013) begin nmis++; $display("FAIL full_head_inst: got %h expected 00000013", id_inst_o); end
  endtask

  task automatic test_drain_wrap();
    // Per cycle: push valid, push pc, expected ready, head before edge, count after edge
    logic        v_t   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] pc_t  [6] = '{32'h10, 32'h10, 32'h14, 32'h0, 32'h0, 32'h0};
    logic        rdy_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] hd_t  [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    logic [2:0]  cnt_t [6] = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 6; i++) begin
      drive(v_t[i], pc_t[i], 1'b1, 1'b0);
      nvec++; if (if_ready_o !== rdy_t[i]) begin nmis++; $display("FAIL drain_ready_%0d: got %b expected %b", i, if_ready_o, rdy_t[i]); end
      nvec++; if (id_pc_o !== hd_t[i]) begin nmis++; $display("FAIL drain_pc_%0d: got %h expected %h", i, id_pc_o, hd_t[i]); end
      nvec++; if (id_inst_o !== inst_of(hd_t[i])) begin nmis++; $display("FAIL drain_inst_%0d: got %h expected %h", i, id_inst_o, inst_of(hd_t[i])); end
      tick();
      nvec++; if (count_o !== cnt_t[i]) begin nmis++; $display("FAIL drain_count_%0d: got %0d expected %0d", i, count_o, cnt_t[i]); end
    end
    nvec++; if (id_valid_o !== 1'b0) begin nmis++; $display("FAIL drain_empty_valid: got %b expected 0", id_valid_o); end
    // Pop attempt while empty must not underflow.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    nvec++; if (count_o !== 3'd0) begin nmis++; $display("FAIL empty_pop_count: got %0d expected 0", count_o); end
    nvec++; if (id_pc_o !== 32'h0) begin nmis++; $display("FAIL empty_pop_pc: got %h expected 0", id_pc_o); end
  endtask

  task automatic test_push_pop_mid();
    drive(1'b1, 32'h30, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h34, 1'b0, 1'b0); tick();
    nvec++; if (count_o !== 3'd2) begin nmis++; $display("FAIL mid_pre_count: got %0d expected 2", count_o); end
    nvec++; if (id_pc_o !== 32'h30) begin nmis++; $display("FAIL mid_pre_head: got %h expected 30", id_pc_o); end
    drive(1'b1, 32'h20, 1'b1, 1'b0); tick();
    nvec++; if (count_o !== 3'd2) begin nmis++; $display("FAIL mid_pp_count: got %0d expected 2", count_o); end
    nvec++; if (id_pc_o !== 32'h34) begin nmis++; $display("FAIL mid_pp_head: got %h expected 34", id_pc_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    nvec++; if (id_pc_o !== 32'h20) begin nmis++; $display("FAIL mid_order_pc: got %h expected 20", id_pc_o); end
    nvec++; if (id_inst_o !== 32'hA000_0020) begin nmis++; $display("FAIL mid_order_inst: got %h expected a0000020", id_inst_o); end
    nvec++; if (count_o !== 3'd1) begin nmis++; $display("FAIL mid_order_count: got %0d expected 1", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    nvec++; if (count_o !== 3'd0) begin nmis++; $display("FAIL mid_drain_count: got %0d expected 0", count_o); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h50, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h54, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h58, 1'b0, 1'b0); tick();
    nvec++; if (count_o !== 3'd3) begin nmis++; $display("FAIL flush_pre_count: got %0d expected 3", count_o); end
    drive(1'b1, 32'h40, 1'b1, 1'b1); tick();
    nvec++; if (count_o !== 3'd0) begin nmis++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    nvec++; if (id_valid_o !== 1'b0) begin nmis++; $display("FAIL flush_valid: got %b expected 0", id_valid_o); end
    nvec++; if (id_pc_o !== 32'h0) begin nmis++; $display("FAIL flush_pc: got %h expected 0", id_pc_o); end
    nvec++; if (id_inst_o !== 32'h0) begin nmis++; $display("FAIL flush_inst: got %h expected 0", id_inst_o); end
    nvec++; if (if_ready_o !== 1'b1) begin nmis++; $display("FAIL flush_ready: got %b expected 1", if_ready_o); end
    // No IF->ID bypass: the push is not visible before its edge.
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    nvec++; if (id_valid_o !== 1'b0) begin nmis++; $display("FAIL no_bypass_valid: got %b expected 0", id_valid_o); end
    tick();
    nvec++; if (id_pc_o !== 32'h80) begin nmis++; $display("FAIL post_flush_head: got %h expected 80", id_pc_o); end
    nvec++; if (count_o !== 3'd1) begin nmis++; $display("FAIL post_flush_count: got %0d expected 1", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    nvec++; if (count_o !== 3'd0) begin nmis++; $display("FAIL post_flush_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h60, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h64, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h68, 1'b0, 1'b0); tick();
    rst = 1'b1;
    drive(1'b1, 32'h6C, 1'b1, 1'b1); tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    nvec++; if (count_o !== 3'd0) begin nmis++; $display("FAIL rstmid_count: got %0d expected 0", count_o); end
    nvec++; if (id_valid_o !== 1'b0) begin nmis++; $display("FAIL rstmid_valid: got %b expected 0", id_valid_o); end
    nvec++; if (id_pc_o !== 32'h0) begin nmis++; $display("FAIL rstmid_pc: got %h expected 0", id_pc_o); end
    nvec++; if (if_ready_o !== 1'b1) begin nmis++; $display("FAIL rstmid_ready: got %b expected 1", if_ready_o); end
    drive(1'b1, 32'h70, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h74, 1'b0, 1'b0); tick();
    nvec++; if (id_pc_o !== 32'h70) begin nmis++; $display("FAIL rstmid_head0: got %h expected 70", id_pc_o); end
    nvec++; if (count_o !== 3'd2) begin nmis++; $display("FAIL rstmid_count2: got %0d expected 2", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    nvec++; if (id_pc_o !== 32'h74) begin nmis++; $display("FAIL rstmid_head1: got %h expected 74", id_pc_o); end
    nvec++; if (id_inst_o !== 32'hA000_0074) begin nmis++; $display("FAIL rstmid_inst1: got %h expected a0000074", id_inst_o); end
  endtask

  initial begin
    rst        = 1'b1;
    flush_i    = 1'b0;
    if_valid_i = 1'b0;
    if_pc_i    = '0;
    if_inst_i  = '0;
    id_ready_i = 1'b0;
    test_reset();
    test_fill();
    test_drain_wrap();
    test_push_pop_mid();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
